gate_bist: RTL and testbench

Built-in self-test engine for a single 2-input logic gate. On a start request it sweeps the four input vectors 00, 01, 10, 11 onto the gate under test and waits a programmable settle time on each. It then compares the gate output against a parameterised truth table and reports pass/fail, an error count and the first failing vector. It sits beside the gate library cells (AND/OR/XOR...) as the hardware counterpart of the per-gate exhaustive testbenches.

---
 rtl/gate_bist.sv | 126 ++++++++++++
 tb/tb_gate_bist.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// Built-in self-test engine for a single 2-input gate: sweeps 00..11, waits a
// programmable settle time per vector, and reports pass/fail against TRUTH.
module gate_bist #(
    parameter logic [3:0]  TRUTH  = 4'b1000,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             y_i,
    output logic             a_o,
    output logic             b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             fail_valid_o,
    output logic [1:0]       fail_vec_o
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state, state_nx;
    logic [1:0]       vec, vec_nx;
    logic [3:0]       settle_cnt, settle_nx;
    logic [ERR_W-1:0] err_nx;
    logic             fail_valid_nx;
    logic [1:0]       fail_vec_nx;
    logic             pass_nx;
    logic             a_nx, b_nx, busy_nx, done_nx;

    always_comb begin
        state_nx      = state;
        vec_nx        = vec;
        settle_nx     = settle_cnt;
        err_nx        = err_cnt_o;
        fail_valid_nx = fail_valid_o;
        fail_vec_nx   = fail_vec_o;
        pass_nx       = pass_o;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx      = APPLY;
                    vec_nx        = '0;
                    settle_nx     = '0;
                    err_nx        = '0;
                    fail_valid_nx = 1'b0;
                    fail_vec_nx   = '0;
                    pass_nx       = 1'b0;
                end
            end
            APPLY: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nx = CHECK;
                end else begin
                    settle_nx = settle_cnt + 4'd1;
                end
            end
            CHECK: begin
                if (y_i != TRUTH[vec]) begin
                    if (err_cnt_o != '1) begin
                        err_nx = err_cnt_o + 1'b1;
                    end
                    if (!fail_valid_o) begin
                        fail_valid_nx = 1'b1;
                        fail_vec_nx   = vec;
                    end
                end
                if (vec == 2'd3) begin
                    state_nx = DONE;
                    // Use the updated count so a mismatch on vector 11 still fails.
                    pass_nx  = (err_nx == '0);
                end else begin
                    state_nx  = APPLY;
                    vec_nx    = vec + 2'd1;
                    settle_nx = '0;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are decoded from the next state and then registered.
        busy_nx = (state_nx == APPLY) || (state_nx == CHECK);
        a_nx    = busy_nx & vec_nx[1];
        b_nx    = busy_nx & vec_nx[0];
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec          <= '0;
            settle_cnt   <= '0;
            err_cnt_o    <= '0;
            fail_valid_o <= 1'b0;
            fail_vec_o   <= '0;
            pass_o       <= 1'b0;
            a_o          <= 1'b0;
            b_o          <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state        <= state_nx;
            vec          <= vec_nx;
            settle_cnt   <= settle_nx;
            err_cnt_o    <= err_nx;
            fail_valid_o <= fail_valid_nx;
            fail_vec_o   <= fail_vec_nx;
            pass_o       <= pass_nx;
            a_o          <= a_nx;
            b_o          <= b_nx;
            busy_o       <= busy_nx;
            done_o       <= done_nx;
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Testbench for gate_bist: three engines (AND/SETTLE=2, XOR/SETTLE=2, XOR/SETTLE=1)
// each driving a configurable gate model with optional output delay.
module tb_gate_bist;

    localparam int unsigned ERR_W = 3;
    localparam int unsigned N     = 3;

    function automatic logic [3:0] dut_tt(input logic [1:0] g);
        return (g == 2'd0) ? 4'b1000 : 4'b0110;
    endfunction

    function automatic int unsigned dut_st(input logic [1:0] g);
        return (g == 2'd2) ? 1 : 2;
    endfunction

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     start, y, a, b, busy, done, pass, fv;
    logic [ERR_W-1:0] ecnt [N];
    logic [1:0]       fvec [N];
    logic [3:0]       gate_tt [N];
    logic [1:0]       gate_dly [N];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam logic [3:0]  TT = dut_tt(2'(g));
        localparam int unsigned ST = dut_st(2'(g));
        logic d1, d2;

        gate_bist #(.TRUTH(TT), .SETTLE(ST), .ERR_W(ERR_W)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start_i      (start[g]),
            .y_i          (y[g]),
            .a_o          (a[g]),
            .b_o          (b[g]),
            .busy_o       (busy[g]),
            .done_o       (done[g]),
            .pass_o       (pass[g]),
            .err_cnt_o    (ecnt[g]),
            .fail_valid_o (fv[g]),
            .fail_vec_o   (fvec[g])
        );

        // Gate under test: truth table lookup, optionally through 1 or 2 flops.
        always_ff @(posedge clk) begin
            d1 <= gate_tt[g][{a[g], b[g]}];
            d2 <= d1;
        end
        assign y[g] = (gate_dly[g] == 2'd0) ? gate_tt[g][{a[g], b[g]}] :
                      (gate_dly[g] == 2'd1) ? d1 : d2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input logic [1:0] g);
        check($sformatf("reset%0d", g),
              32'({a[g], b[g], busy[g], done[g], pass[g], fv[g], fvec[g], ecnt[g]}), 32'(0));
    endtask

    // One full sweep on engine g against a gate model; expectations come from
    // which input vector the gate actually saw m_dly cycles before each sample.
    task automatic run_sweep(input logic [1:0] g, input logic [3:0] m_tt,
                             input logic [1:0] m_dly, input bit hold);
        int unsigned s     = dut_st(g);
        int unsigned total = 4 * (s + 1);
        logic [3:0]  truth = dut_tt(g);
        int unsigned errs  = 0;
        bit          fval  = 1'b0;
        logic [1:0]  fvx   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            int c = int'((k + 1) * (s + 1)) - int'(m_dly);
            int v = (c >= 1) ? (c - 1) / int'(s + 1) : 0;
            if (m_tt[2'(v)] != truth[2'(k)]) begin
                errs++;
                if (!fval) begin
                    fval = 1'b1;
                    fvx  = 2'(k);
                end
            end
        end
        if (errs > (1 << ERR_W) - 1) errs = (1 << ERR_W) - 1;

        gate_tt[g]  = m_tt;
        gate_dly[g] = m_dly;
        repeat (3) @(negedge clk);
        start[g] = 1'b1;
        for (int unsigned c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            if (!hold) start[g] = 1'b0;
            if (c == 1)
                check($sformatf("clear%0d", g), 32'({pass[g], fv[g], ecnt[g]}), 32'(0));
            if (c <= total) begin
                check($sformatf("vec%0d.c%0d", g, c), 32'({a[g], b[g]}), 32'((c - 1) / (s + 1)));
                check($sformatf("busy%0d.c%0d", g, c), 32'({busy[g], done[g]}), 32'(2'b10));
            end else begin
                check($sformatf("done%0d", g), 32'({busy[g], done[g], a[g], b[g]}), 32'(4'b0100));
                check($sformatf("pass%0d", g), 32'(pass[g]), 32'(errs == 0));
                check($sformatf("errcnt%0d", g), 32'(ecnt[g]), 32'(errs));
                check($sformatf("fvalid%0d", g), 32'(fv[g]), 32'(fval));
                check($sformatf("fvec%0d", g), 32'(fvec[g]), 32'(fvx));
            end
        end
        @(negedge clk);
        check($sformatf("idle%0d", g), 32'({busy[g], done[g]}), 32'(0));
        start[g] = 1'b0;
        @(negedge clk);
        check($sformatf("stay_idle%0d", g), 32'({busy[g], done[g]}), 32'(0));
        check($sformatf("hold%0d", g), 32'({pass[g], fv[g], fvec[g], ecnt[g]}),
              32'({errs == 0, fval, fvx, 3'(errs)}));
    endtask

    initial begin
        int unsigned n_done;
        rst_n = 1'b0;
        start = '0;
        for (int i = 0; i < N; i++) begin
            gate_tt[i]  = 4'b1000;
            gate_dly[i] = 2'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) check_reset(2'(i));
        rst_n = 1'b1;

        run_sweep(2'd0, 4'b1000, 2'd0, 1'b0);   // correct AND
        run_sweep(2'd0, 4'b0000, 2'd0, 1'b0);   // stuck-at-0
        run_sweep(2'd0, 4'b1110, 2'd0, 1'b0);   // OR against AND table
        run_sweep(2'd0, 4'b1000, 2'd0, 1'b0);
        run_sweep(2'd0, 4'b1000, 2'd0, 1'b1);   // start held through DONE
        run_sweep(2'd0, 4'b1110, 2'd0, 1'b0);

        // Reset pulse during APPLY of vector 10 aborts without done.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_vec", 32'({a[0], b[0], busy[0]}), 32'(3'b101));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) check_reset(2'(i));
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done[0] || busy[0]) n_done++;
        end
        check("no_done_after_reset", 32'(n_done), 32'(0));
        run_sweep(2'd0, 4'b1000, 2'd0, 1'b0);

        run_sweep(2'd1, 4'b0110, 2'd2, 1'b0);   // delayed XOR, SETTLE=2
        run_sweep(2'd2, 4'b0110, 2'd2, 1'b0);   // delayed XOR, SETTLE=1
        run_sweep(2'd2, 4'b0110, 2'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_sweep(2'($urandom_range(0, 2)), 4'($urandom), 2'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
